// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op codes, reset level,
// FSM state encoding and byte-enable base patterns.
package mem_stage_pkg;

    localparam logic RstEnable = 1'b1;

    // Existing ALU op codes
    localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

    typedef enum logic [0:0] {StIdle, StAccess} mem_state_e;

    // Big-endian: offset 0 is the most significant lane
    localparam logic [3:0] BeByte = 4'b1000;
    localparam logic [3:0] BeHalf = 4'b1100;
    localparam logic [3:0] BeWord = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for loads and stores: byte enables, store
// data replication, load extraction/extension and misalignment detection.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select the addressed byte and halfword lanes out of the read word
    always_comb begin
        rbyte = rdata[31:24];
        case (offset)
            2'd0: rbyte = rdata[31:24];
            2'd1: rbyte = rdata[23:16];
            2'd2: rbyte = rdata[15:8];
            2'd3: rbyte = rdata[7:0];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    // Decode op into enables, store data, load value and alignment check
    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata      = 32'h0;
        load_data  = 32'h0;
        case (op)
            EXE_LB_OP: begin
                is_mem    = 1'b1;
                be        = BeByte >> offset;
                load_data = {{24{rbyte[7]}}, rbyte};
            end
            EXE_LBU_OP: begin
                is_mem    = 1'b1;
                be        = BeByte >> offset;
                load_data = {24'h0, rbyte};
            end
            EXE_LH_OP: begin
                is_mem     = 1'b1;
                misaligned = offset[0];
                be         = BeHalf >> offset;
                load_data  = {{16{rhalf[15]}}, rhalf};
            end
            EXE_LHU_OP: begin
                is_mem     = 1'b1;
                misaligned = offset[0];
                be         = BeHalf >> offset;
                load_data  = {16'h0, rhalf};
            end
            EXE_LW_OP: begin
                is_mem     = 1'b1;
                misaligned = |offset;
                be         = BeWord;
                load_data  = rdata;
            end
            EXE_SB_OP: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                be       = BeByte >> offset;
                wdata    = {4{store_data[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                misaligned = offset[0];
                be         = BeHalf >> offset;
                wdata      = {2{store_data[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                misaligned = |offset;
                be         = BeWord;
                wdata      = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes non-memory results through with one cycle of
// latency, runs loads/stores over a req/ack bus with a timeout abort, and
// registers the final result toward write-back.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [7:0]  ex_aluop_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_mem_data_i,
    output logic        stall_req_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        buserr_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      op_q;
    logic [4:0]      wd_q;
    logic            wreg_q;
    logic [1:0]      off_q;

    logic [7:0]  sel_op;
    logic [1:0]  sel_off;
    logic        is_mem, is_store, misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;
    logic        accept, timeout_hit;

    // One aligner serves both directions: EX op while idle, captured op while accessing
    assign sel_op  = (state_q == StAccess) ? op_q  : ex_aluop_i;
    assign sel_off = (state_q == StAccess) ? off_q : ex_mem_addr_i[1:0];

    mem_lane_align u_lane (
        .op         (sel_op),
        .offset     (sel_off),
        .store_data (ex_mem_data_i),
        .rdata      (dbus_rdata_i),
        .is_mem     (is_mem),
        .is_store   (is_store),
        .misaligned (misaligned),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign accept      = (state_q == StIdle) && ex_valid_i && is_mem && !misaligned;
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
    // Stall drops in the completing cycle so EX can advance at that edge
    assign stall_req_o = accept || ((state_q == StAccess) && !dbus_ack_i && !timeout_hit);

    // FSM, timeout counter, bus and write-back output registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= 8'h0;
            wd_q         <= 5'h0;
            wreg_q       <= 1'b0;
            off_q        <= 2'b00;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'h0;
            dbus_be_o    <= 4'h0;
            dbus_wdata_o <= 32'h0;
            wb_valid_o   <= 1'b0;
            wb_wd_o      <= 5'h0;
            wb_wreg_o    <= 1'b0;
            wb_wdata_o   <= 32'h0;
            adel_o       <= 1'b0;
            ades_o       <= 1'b0;
            buserr_o     <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            wb_wreg_o  <= 1'b0;
            adel_o     <= 1'b0;
            ades_o     <= 1'b0;
            buserr_o   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ex_valid_i) begin
                        wb_wd_o <= ex_wd_i;
                        if (!is_mem) begin
                            wb_valid_o <= 1'b1;
                            wb_wreg_o  <= ex_wreg_i;
                            wb_wdata_o <= ex_wdata_i;
                        end else if (misaligned) begin
                            wb_valid_o <= 1'b1;
                            wb_wdata_o <= 32'h0;
                            adel_o     <= !is_store;
                            ades_o     <= is_store;
                        end else begin
                            state_q      <= StAccess;
                            cnt_q        <= '0;
                            op_q         <= ex_aluop_i;
                            wd_q         <= ex_wd_i;
                            wreg_q       <= ex_wreg_i && !is_store;
                            off_q        <= ex_mem_addr_i[1:0];
                            dbus_req_o   <= 1'b1;
                            dbus_we_o    <= is_store;
                            dbus_addr_o  <= {ex_mem_addr_i[31:2], 2'b00};
                            dbus_be_o    <= lane_be;
                            dbus_wdata_o <= is_store ? lane_wdata : 32'h0;
                        end
                    end
                end
                StAccess: begin
                    if (dbus_ack_i || timeout_hit) begin
                        state_q      <= StIdle;
                        dbus_req_o   <= 1'b0;
                        dbus_we_o    <= 1'b0;
                        dbus_addr_o  <= 32'h0;
                        dbus_be_o    <= 4'h0;
                        dbus_wdata_o <= 32'h0;
                        wb_valid_o   <= 1'b1;
                        wb_wd_o      <= wd_q;
                        // Ack wins over a simultaneous timeout
                        if (dbus_ack_i) begin
                            wb_wreg_o  <= wreg_q;
                            wb_wdata_o <= is_store ? 32'h0 : lane_load;
                        end else begin
                            wb_wdata_o <= 32'h0;
                            buserr_o   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic [7:0]  ex_aluop_i;
    logic [31:0] ex_mem_addr_i;
    logic [31:0] ex_mem_data_i;
    logic        stall_req_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        adel_o;
    logic        ades_o;
    logic        buserr_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_i    (ex_valid_i),
        .ex_wd_i       (ex_wd_i),
        .ex_wreg_i     (ex_wreg_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_aluop_i    (ex_aluop_i),
        .ex_mem_addr_i (ex_mem_addr_i),
        .ex_mem_data_i (ex_mem_data_i),
        .stall_req_o   (stall_req_o),
        .dbus_req_o    (dbus_req_o),
        .dbus_we_o     (dbus_we_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_be_o     (dbus_be_o),
        .dbus_wdata_o  (dbus_wdata_o),
        .dbus_ack_i    (dbus_ack_i),
        .dbus_rdata_i  (dbus_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_wd_o       (wb_wd_o),
        .wb_wreg_o     (wb_wreg_o),
        .wb_wdata_o    (wb_wdata_o),
        .adel_o        (adel_o),
        .ades_o        (ades_o),
        .buserr_o      (buserr_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] addr,
                           input logic [31:0] sdata);
        ex_valid_i    = 1'b1;
        ex_aluop_i    = op;
        ex_wd_i       = wd;
        ex_wreg_i     = wreg;
        ex_wdata_i    = wdata;
        ex_mem_addr_i = addr;
        ex_mem_data_i = sdata;
    endtask

    task automatic test_reset();
        logic [146:0] all_out;
        rst = 1'b1;
        step();
        all_out = {stall_req_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
                   wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o, adel_o, ades_o, buserr_o,
                   42'h0};
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        present(EXE_OR_OP, 5'd5, 1'b1, 32'h0000FFFF, 32'h0, 32'h0);
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            failures++; $display("FAIL pt_stall: got %b required 0", stall_req_o);
        end
        step();
        ex_valid_i = 1'b0;
        checks++;
        if ({wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o, dbus_req_o} !== {1'b1, 5'd5, 1'b1, 32'h0000FFFF, 1'b0}) begin
            failures++;
            $display("FAIL pt_result: got v=%b wd=%0d wreg=%b data=%h req=%b required v=1 wd=5 wreg=1 data=0000ffff req=0",
                     wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o, dbus_req_o);
        end
        step();
        checks++;
        if ({wb_valid_o, wb_wreg_o} !== 2'b00) begin
            failures++; $display("FAIL pt_pulse: got v=%b wreg=%b required 0 0", wb_valid_o, wb_wreg_o);
        end
    endtask

    task automatic test_load_byte(input logic [7:0] op, input logic [31:0] exp);
        int stalls;
        present(op, 5'd9, 1'b1, 32'h0, 32'h00000103, 32'h0);
        dbus_rdata_i = 32'h11223380;
        #1;
        stalls = stall_req_o ? 1 : 0;
        step();
        checks++;
        if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o} !== {1'b1, 1'b0, 32'h100, 4'b0001}) begin
            failures++;
            $display("FAIL lb_bus op=%h: got req=%b we=%b addr=%h be=%b required 1 0 00000100 0001",
                     op, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o);
        end
        for (int i = 0; i < 3; i++) begin
            if (stall_req_o) stalls++;
            step();
        end
        dbus_ack_i = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            failures++; $display("FAIL lb_stall_ack op=%h: got %b required 0", op, stall_req_o);
        end
        ex_valid_i = 1'b0;
        step();
        dbus_ack_i = 1'b0;
        checks++;
        if (stalls != 4) begin
            failures++; $display("FAIL lb_stall_cycles op=%h: got %0d required 4", op, stalls);
        end
        checks++;
        if ({wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o, dbus_req_o} !== {1'b1, 5'd9, 1'b1, exp, 1'b0}) begin
            failures++;
            $display("FAIL lb_result op=%h: got v=%b wd=%0d wreg=%b data=%h req=%b required v=1 wd=9 wreg=1 data=%h req=0",
                     op, wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o, dbus_req_o, exp);
        end
        step();
    endtask

    task automatic test_store_half();
        present(EXE_SH_OP, 5'd3, 1'b1, 32'h0, 32'h00000202, 32'hDEADBEEF);
        #1;
        checks++;
        if (stall_req_o !== 1'b1) begin
            failures++; $display("FAIL sh_stall: got %b required 1", stall_req_o);
        end
        step();
        ex_valid_i = 1'b0;
        checks++;
        if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o} !==
            {1'b1, 1'b1, 32'h200, 4'b0011, 32'hBEEFBEEF}) begin
            failures++;
            $display("FAIL sh_bus: got req=%b we=%b addr=%h be=%b wdata=%h required 1 1 00000200 0011 beefbeef",
                     dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o);
        end
        dbus_ack_i = 1'b1;
        step();
        dbus_ack_i = 1'b0;
        checks++;
        if ({wb_valid_o, wb_wreg_o, dbus_req_o} !== 3'b100) begin
            failures++;
            $display("FAIL sh_result: got v=%b wreg=%b req=%b required 1 0 0", wb_valid_o, wb_wreg_o, dbus_req_o);
        end
        step();
    endtask

    task automatic test_misaligned();
        present(EXE_LW_OP, 5'd4, 1'b1, 32'h0, 32'h00000301, 32'h0);
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            failures++; $display("FAIL mis_lw_stall: got %b required 0", stall_req_o);
        end
        step();
        ex_valid_i = 1'b0;
        checks++;
        if ({dbus_req_o, wb_valid_o, wb_wreg_o, adel_o, ades_o} !== 5'b01010) begin
            failures++;
            $display("FAIL mis_lw: got req=%b v=%b wreg=%b adel=%b ades=%b required 0 1 0 1 0",
                     dbus_req_o, wb_valid_o, wb_wreg_o, adel_o, ades_o);
        end
        present(EXE_SW_OP, 5'd4, 1'b1, 32'h0, 32'h00000302, 32'h12345678);
        step();
        ex_valid_i = 1'b0;
        checks++;
        if ({dbus_req_o, wb_valid_o, wb_wreg_o, adel_o, ades_o} !== 5'b01001) begin
            failures++;
            $display("FAIL mis_sw: got req=%b v=%b wreg=%b adel=%b ades=%b required 0 1 0 0 1",
                     dbus_req_o, wb_valid_o, wb_wreg_o, adel_o, ades_o);
        end
        step();
        checks++;
        if ({wb_valid_o, adel_o, ades_o} !== 3'b000) begin
            failures++; $display("FAIL mis_pulse: got v=%b adel=%b ades=%b required 0 0 0", wb_valid_o, adel_o, ades_o);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        present(EXE_LW_OP, 5'd7, 1'b1, 32'h0, 32'h00000400, 32'h0);
        step();
        ex_valid_i = 1'b0;
        while (dbus_req_o === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            step();
        end
        checks++;
        if (req_cycles != 16) begin
            failures++; $display("FAIL to_req_cycles: got %0d required 16", req_cycles);
        end
        checks++;
        if ({wb_valid_o, wb_wreg_o, buserr_o, stall_req_o, dbus_req_o} !== 5'b10100) begin
            failures++;
            $display("FAIL to_abort: got v=%b wreg=%b buserr=%b stall=%b req=%b required 1 0 1 0 0",
                     wb_valid_o, wb_wreg_o, buserr_o, stall_req_o, dbus_req_o);
        end
        step();
        checks++;
        if ({wb_valid_o, buserr_o} !== 2'b00) begin
            failures++; $display("FAIL to_pulse: got v=%b buserr=%b required 0 0", wb_valid_o, buserr_o);
        end
    endtask

    task automatic test_ack_at_timeout();
        present(EXE_LW_OP, 5'd8, 1'b1, 32'h0, 32'h00000404, 32'h0);
        step();
        ex_valid_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'hCAFEF00D;
        step();
        dbus_ack_i = 1'b0;
        checks++;
        if ({wb_valid_o, wb_wreg_o, buserr_o, wb_wdata_o} !== {3'b110, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL ack_vs_timeout: got v=%b wreg=%b buserr=%b data=%h required 1 1 0 cafef00d",
                     wb_valid_o, wb_wreg_o, buserr_o, wb_wdata_o);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        present(EXE_LW_OP, 5'd10, 1'b1, 32'h0, 32'h00000500, 32'h0);
        step();
        ex_valid_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({dbus_req_o, dbus_addr_o, dbus_be_o, wb_valid_o, stall_req_o} !== '0) begin
            failures++;
            $display("FAIL rst_mid: got req=%b addr=%h be=%b v=%b stall=%b required all 0",
                     dbus_req_o, dbus_addr_o, dbus_be_o, wb_valid_o, stall_req_o);
        end
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'h55AA55AA;
        step();
        dbus_ack_i = 1'b0;
        checks++;
        if ({wb_valid_o, wb_wdata_o, dbus_req_o} !== '0) begin
            failures++;
            $display("FAIL rst_late_ack: got v=%b data=%h req=%b required 0 0 0", wb_valid_o, wb_wdata_o, dbus_req_o);
        end
        step();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            failures++; $display("FAIL rst_no_wb: got %b required 0", wb_valid_o);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ex_valid_i    = 1'b0;
        ex_wd_i       = 5'h0;
        ex_wreg_i     = 1'b0;
        ex_wdata_i    = 32'h0;
        ex_aluop_i    = 8'h0;
        ex_mem_addr_i = 32'h0;
        ex_mem_data_i = 32'h0;
        dbus_ack_i    = 1'b0;
        dbus_rdata_i  = 32'h0;
        step();
        test_reset();
        test_passthrough();
        test_load_byte(EXE_LB_OP, 32'hFFFFFF80);
        test_load_byte(EXE_LBU_OP, 32'h00000080);
        test_store_half();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes EX results: destination register, write enable, ALU result, memory-op code, effective address, store data.
- Performs loads/stores over a req/ack data bus, raises a pipeline stall while an access is outstanding, and registers the final result toward write-back.
- Non-memory ops pass through with one cycle of latency.

Parameters:
- TIMEOUT, 16: cycles without dbus_ack_i before an access is aborted with a bus error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  EX presents an instruction this cycle
- ex_wd_i  in  5  destination register address
- ex_wreg_i  in  1  register write enable
- ex_wdata_i  in  32  EX result (non-memory ops)
- ex_aluop_i  in  8  op code; memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW
- ex_mem_addr_i  in  32  effective address
- ex_mem_data_i  in  32  store data (rt)
- stall_req_o  out  1  upstream must hold EX inputs stable
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_ack_i  in  1  access complete; rdata valid this cycle
- dbus_rdata_i  in  32  load data
- wb_valid_o  out  1  result valid to WB
- wb_wd_o  out  5  destination address
- wb_wreg_o  out  1  write enable
- wb_wdata_o  out  32  final result
- adel_o  out  1  load address error (pulse, with wb_valid_o)
- ades_o  out  1  store address error (pulse, with wb_valid_o)
- buserr_o  out  1  timeout abort (pulse, with wb_valid_o)

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0, including wb_wdata_o and dbus_*.
  - Reset mid-access drops the request immediately; a later ack is ignored.
- States IDLE, ACCESS.
- IDLE, ex_valid_i=1, non-memory op:
  - Next edge: wb_valid_o=1, wb_wd/wreg/wdata = ex inputs.
  - Latency 1; stall_req_o stays 0.
- IDLE, memory op, misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0):
  - No bus request.
  - Next edge: wb_valid_o=1, wb_wreg_o=0, adel_o (loads) or ades_o (stores) = 1.
- IDLE, memory op, aligned:
  - stall_req_o=1 combinationally in the acceptance cycle.
  - Next edge: capture op, wd, wreg, addr and data; go to ACCESS; drive dbus_req_o=1.
- ACCESS:
  - stall_req_o=1; dbus_* held constant; EX inputs ignored.
  - Timeout counter increments each cycle without ack.
- ACCESS exit on dbus_ack_i=1:
  - Result registered at that edge; wb_valid_o=1 the next cycle; state returns to IDLE.
  - stall_req_o falls in the ack cycle, so EX may present the next op the cycle after ack.
- ACCESS exit on counter reaching TIMEOUT-1 without ack:
  - Return to IDLE with wb_valid_o=1, wb_wreg_o=0, buserr_o=1.
  - dbus_req_o drops.
- Ack and timeout in the same cycle: ack wins.
- wb_valid_o is a single-cycle pulse per instruction. When ex_valid_i=0 in IDLE, wb_valid_o=0 and wb_wreg_o=0.
- Byte lanes are big-endian; offset o = addr[1:0].
  - Byte: be = 4'b1000 >> o; lane = data[31-8o : 24-8o].
  - Half: be = 4'b1100 >> o, o ∈ {0,2}.
  - Word: be = 4'b1111.
- Store data replicated across lanes:
  - SB: {4{rt[7:0]}}
  - SH: {2{rt[15:0]}}
  - SW: rt
- Load extraction selects the lane per offset:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW takes the full word.
- Stores complete with wb_wreg_o=0 regardless of ex_wreg_i.
- dbus_we_o=1 only for SB/SH/SW.

Decomposition:
- Shared package/defines:
  - The existing op codes (EXE_LB_OP … EXE_SW_OP) and RstEnable.
  - New constants for state encodings and byte-enable patterns.
- Sub-module mem_lane_align (combinational), used for both directions:
  - Store path: computes dbus_be_o and dbus_wdata_o from op, offset and rt.
  - Load path: computes the extended load value from op, offset and rdata.
  - Also flags misalignment.
- FSM, counter and output registers stay in mem_stage.

Test Plan:
- Pass-through:
  - Stimulus: OR op, wd=5, wreg=1, wdata=0x0000FFFF.
  - Required: next cycle wb_valid=1, wb_wd=5, wb_wdata=0x0000FFFF; stall_req never asserted.
- LB, signed byte:
  - Stimulus: addr=0x103, rdata=0x11223380, ack after 3 cycles.
  - Required: dbus_addr=0x100, be=0001; stall_req high 4 cycles; wb_wdata=0xFFFFFF80.
  - Repeat with LBU: wb_wdata=0x00000080.
- SH:
  - Stimulus: addr=0x202, rt=0xDEADBEEF.
  - Required: be=0011, wdata=0xBEEFBEEF, we=1; after ack, wb_valid=1, wb_wreg=0.
- Misaligned:
  - Stimulus: LW addr=0x301.
  - Required: no dbus_req; next cycle adel_o=1, wb_wreg=0.
  - Repeat with SW addr=0x302: ades_o=1.
- Timeout:
  - Stimulus: LW with no ack.
  - Required: dbus_req held 16 cycles, then buserr_o=1 for 1 cycle, wb_wreg=0, stall_req drops.
  - Ack and timeout in the same cycle: normal load result.
- Reset mid-access:
  - Stimulus: rst=1 two cycles into an LW, then ack arrives after reset.
  - Required: all outputs 0, state IDLE, the ack ignored, no wb_valid_o.
